jt49_period_meter: RTL

//  Measures the half-period of a PSG-style square wave, such as the toggle output of the tone/noise

---
 rtl/jt49_period_meter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/jt49_period_meter.sv
// Half-period meter for a PSG-style square wave: counts cen ticks between din edges
// and publishes the count as a divider period code on a valid/ready output.
module jt49_period_meter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] per,
    output logic         ovf,
    output logic         valid,
    input  logic         ready,
    output logic         lost
);

    typedef enum logic {
        SYNC = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;
    logic         din_q, din_d;
    logic [W-1:0] per_q, per_d;
    logic         ovf_q, ovf_d;
    logic         valid_q, valid_d;
    logic         lost_q, lost_d;
    logic         edge_det;
    logic         publish;

    assign edge_det = cen && (din != din_q);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        din_d   = din_q;
        per_d   = per_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        lost_d  = lost_q;
        publish = 1'b0;

        // Restart resamples din so leaving SYNC never sees a stale edge.
        if (clr) begin
            state_d = SYNC;
            cnt_d   = '0;
            sat_d   = 1'b0;
            din_d   = din;
        end else if (cen) begin
            din_d = din;
            case (state_q)
                SYNC: begin
                    if (edge_det) begin
                        state_d = MEAS;
                        cnt_d   = CNT_ONE;
                        sat_d   = 1'b0;
                    end
                end
                MEAS: begin
                    if (edge_det) begin
                        publish = 1'b1;
                        cnt_d   = CNT_ONE;
                        sat_d   = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        if (clr) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end else if (publish) begin
            per_d   = cnt_q;
            ovf_d   = sat_q;
            valid_d = 1'b1;
            // Lost only when an unconsumed result is overwritten; a same-cycle accept clears it.
            if (valid_q) lost_d = !ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            din_q   <= 1'b0;
            per_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            din_q   <= din_d;
            per_q   <= per_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
        end
    end

    assign per   = per_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;
    assign lost  = lost_q;

endmodule
